// File: rtl/div16_nr_if.sv
// Handshake and result bundle for the 16-bit non-restoring divider.
interface div16_nr_if;
   logic        start;
   logic [15:0] x;
   logic [15:0] y;
   logic        busy;
   logic        done;
   logic [15:0] q;
   logic [15:0] r;
   logic        div_by_zero;

   // Requester side: issues start with operands, observes status and results.
   modport master (
      output start, x, y,
      input  busy, done, q, r, div_by_zero
   );

   // Divider side.
   modport slave (
      input  start, x, y,
      output busy, done, q, r, div_by_zero
   );
endinterface

// File: rtl/div16_nr.sv
// Sequential 16-bit unsigned non-restoring divider.
// One 17-bit add/subtract step per cycle on a signed partial remainder,
// followed by one remainder-correction cycle and a single-cycle done pulse.
module div16_nr (
   input  logic       clk,
   input  logic       rst,
   div16_nr_if.slave  bus
);
   localparam int unsigned WIDTH = 16;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_CORR = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;      // signed partial remainder
   logic [WIDTH-1:0] qr_q, qr_d;    // dividend, shifted into quotient
   logic [WIDTH-1:0] m_q, m_d;      // divisor
   logic [4:0]       cnt_q, cnt_d;  // remaining iterations
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   a_step;
   logic [WIDTH:0]   a_fix;

   // Next-state, datapath step and result-load logic.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      qr_d    = qr_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;

      // Shift {A,Q} left, then add or subtract M depending on the old sign of A.
      a_shift = {a_q[WIDTH-1:0], qr_q[WIDTH-1]};
      a_step  = a_q[WIDTH] ? (a_shift + {1'b0, m_q}) : (a_shift - {1'b0, m_q});
      // Negative final remainder is restored by one extra add.
      a_fix   = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d   = '0;
               qr_d  = bus.x;
               m_d   = bus.y;
               cnt_d = 5'd16;
               dbz_d = 1'b0;
               if (bus.y == '0) begin
                  q_d     = '1;
                  r_d     = bus.x;
                  dbz_d   = 1'b1;
                  state_d = S_FIN;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            a_d   = a_step;
            qr_d  = {qr_q[WIDTH-2:0], ~a_step[WIDTH]};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = S_CORR;
         end
         S_CORR: begin
            a_d     = a_fix;
            q_d     = qr_q;
            r_d     = a_fix[WIDTH-1:0];
            state_d = S_FIN;
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         qr_q    <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         qr_q    <= qr_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.busy        = (state_q == S_CALC) || (state_q == S_CORR);
   assign bus.done        = (state_q == S_FIN);
   assign bus.q           = q_q;
   assign bus.r           = r_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div16_nr.sv
// Self-checking bench for div16_nr: directed vector table plus
// hand-written sequences for ignored starts and mid-run reset.
module tb_div16_nr;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   div16_nr_if bus ();

   div16_nr u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] eq;
      logic [15:0] er;
      logic        edbz;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Issue one request, scramble operands after accept, wait (bounded) for done.
   task automatic run_div(input logic [15:0] xv, input logic [15:0] yv,
                          output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.x     = xv;
      bus.y     = yv;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.x     = ~xv;
      bus.y     = yv + 16'd3;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.busy) bcnt++;
         if (bus.done) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int bcnt;
      int n;
      tests = 0;
      fails = 0;

      vecs[0]  = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
      vecs[1]  = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0};
      vecs[2]  = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0};
      vecs[3]  = '{16'd3,     16'd10,    16'd0,     16'd3,     1'b0};
      vecs[4]  = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b0};
      vecs[5]  = '{16'd5,     16'd0,     16'hFFFF,  16'd5,     1'b1};
      vecs[6]  = '{16'd12345, 16'd123,   16'd100,   16'd45,    1'b0};
      vecs[7]  = '{16'd65535, 16'd256,   16'd255,   16'd255,   1'b0};
      vecs[8]  = '{16'd40000, 16'd40001, 16'd0,     16'd40000, 1'b0};
      vecs[9]  = '{16'd0,     16'd0,     16'hFFFF,  16'd0,     1'b1};
      vecs[10] = '{16'd500,   16'd7,     16'd71,    16'd3,     1'b0};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.x     = 16'd0;
      bus.y     = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_q", int'(bus.q), 0);
      chk("reset_r", int'(bus.r), 0);
      chk("reset_dbz", int'(bus.div_by_zero), 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_div(vecs[i].x, vecs[i].y, lat, bcnt);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].edbz ? 1 : 18);
         chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].edbz ? 0 : 17);
         chk($sformatf("v%0d_q", i), int'(bus.q), int'(vecs[i].eq));
         chk($sformatf("v%0d_r", i), int'(bus.r), int'(vecs[i].er));
         chk($sformatf("v%0d_dbz", i), int'(bus.div_by_zero), int'(vecs[i].edbz));
         repeat (2) @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), int'(bus.done), 0);
         chk($sformatf("v%0d_q_hold", i), int'(bus.q), int'(vecs[i].eq));
      end

      // 1000/3 with a second start (9/2) during CALC, then a start during FIN.
      lat  = -1;
      bcnt = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.x     = 16'd1000;
      bus.y     = 16'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 5) begin
            bus.start = 1'b1;
            bus.x     = 16'd9;
            bus.y     = 16'd2;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.busy) bcnt++;
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      chk("ign_latency", lat, 18);
      chk("ign_busy_cycles", bcnt, 17);
      chk("ign_q", int'(bus.q), 333);
      chk("ign_r", int'(bus.r), 1);
      // start asserted during the FIN cycle must be dropped
      bus.start = 1'b1;
      bus.x     = 16'd9;
      bus.y     = 16'd2;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("fin_start_busy", int'(bus.busy), 0);
      chk("fin_start_done", int'(bus.done), 0);
      repeat (3) @(negedge clk);
      chk("fin_start_idle_busy", int'(bus.busy), 0);
      chk("fin_start_q_hold", int'(bus.q), 333);

      // 500/7 aborted by reset during CALC.
      @(negedge clk);
      bus.start = 1'b1;
      bus.x     = 16'd500;
      bus.y     = 16'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_abort_busy", int'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_q", int'(bus.q), 0);
      chk("abort_r", int'(bus.r), 0);
      chk("abort_dbz", int'(bus.div_by_zero), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_late_done", int'(bus.done), 0);
      chk("abort_stays_idle", int'(bus.busy), 0);
      run_div(16'd500, 16'd7, lat, bcnt);
      chk("rerun_latency", lat, 18);
      chk("rerun_q", int'(bus.q), 71);
      chk("rerun_r", int'(bus.r), 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/div16_nr.md
# div16_nr

Sequential 16-bit unsigned non-restoring divider for the ALU16 datapath. It is the inverse arithmetic path to the 17-bit ripple-carry adder. It reuses one 17-bit add/subtract step per cycle on a signed partial remainder to produce quotient and remainder. The block starts on a single-cycle `start` pulse, reports `busy` while running, and pulses `done` when the result is ready. Results are held stable until the next accepted `start`.

## Interface
- `WIDTH`, 16, operand width. Fixed at 16. The partial remainder is `WIDTH+1` = 17 bits.
- `clk  in  1`  system clock. All state updates on the rising edge.
- `rst  in  1`  reset. Synchronous, active-high.
- `start  in  1`  request pulse. Sampled only in IDLE.
- `x  in  16`  dividend, unsigned. Captured on accept.
- `y  in  16`  divisor, unsigned. Captured on accept.
- `busy  out  1`  high in CALC and CORR.
- `done  out  1`  one-cycle pulse when `q`, `r` and `div_by_zero` become valid.
- `q  out  16`  quotient.
- `r  out  16`  remainder.
- `div_by_zero  out  1`  set when the captured `y` was 0. Held with the results.

## Operation
- Registers:
  - `A[16:0]`: signed partial remainder.
  - `Q[15:0]`: dividend, then quotient.
  - `M[15:0]`: divisor.
  - `cnt[4:0]`: iteration counter.
- States: IDLE, CALC, CORR, FIN.
- IDLE, with `start`=1:
  - Capture: `A`=0, `Q`=`x`, `M`=`y`, `cnt`=16. Clear `div_by_zero`.
  - If `y`==0, go to FIN with `q`=16'hFFFF, `r`=`x`, `div_by_zero`=1.
  - Otherwise go to CALC.
- CALC, one iteration per cycle:
  - Shift `{A,Q}` left by 1.
  - If the old `A[16]` was 0, `A` = shifted `A` − `{1'b0,M}`. Else `A` = shifted `A` + `{1'b0,M}`.
  - Set `Q[0]` = ~new `A[16]`.
  - Decrement `cnt`. When `cnt` reaches 0 after the decrement, go to CORR.
- CORR:
  - If `A[16]`, `A` = `A` + `{1'b0,M}`.
  - Load `q` = `Q`, `r` = `A[15:0]`, then go to FIN.
- FIN: assert `done` for this cycle only, then go to IDLE.
- Arithmetic: all add/subtract is 17-bit two's complement. Carry-out beyond bit 16 is discarded. The final remainder always satisfies 0 ≤ `r` < `y`.
- `start` outside IDLE is ignored. No queueing, and operands are not re-captured.
- `start` in the same cycle as a FIN exit is ignored. A new request is accepted only while in IDLE.
- `x`, `y` may change freely after capture without effect.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `q`=0, `r`=0, `div_by_zero`=0. Internal registers are cleared.
- `rst` mid-operation aborts at the next edge and forces all outputs to their reset values. Any result in flight is lost. `rst` has priority over `start`.
- Normal divide: `start` sampled at edge E0.
  - CALC occupies edges E1..E16.
  - CORR occurs at edge E17.
  - `done`=1 during the cycle after E17, i.e. 18 cycles after E0.
  - `busy`=1 from after E0 until E17.
- Divide by zero: `done`=1 in the cycle after E0, and `busy` stays 0.
- `q`, `r` and `div_by_zero` change only on the CORR or FIN load edge. They are stable otherwise, including through IDLE.
- Back-to-back throughput: one divide per 19 cycles (accept, 16 CALC, CORR, FIN).

## Test plan
- `x`=100, `y`=7, one `start` pulse -> `done` 18 cycles later with `q`=14, `r`=2, `div_by_zero`=0. `busy` high for exactly 17 cycles.
- `x`=16'hFFFF, `y`=1 -> `q`=16'hFFFF, `r`=0. Then `x`=16'hFFFF, `y`=16'hFFFF -> `q`=1, `r`=0.
- `x`=3, `y`=10 -> `q`=0, `r`=3. Then `x`=0, `y`=5 -> `q`=0, `r`=0.
- `x`=5, `y`=0 -> `done` in the cycle after accept, `q`=16'hFFFF, `r`=5, `div_by_zero`=1, `busy` never high.
- Start 1000/3, then pulse `start` with 9/2 at cycle 5 -> second request ignored. The result is `q`=333, `r`=1, and `x`/`y` changes mid-run have no effect.
- Start 500/7, assert `rst` at cycle 8 -> all outputs 0 and state IDLE the next cycle. A new 500/7 then completes normally with `q`=71, `r`=3.
